cpu_run_monitor: RTL and testbench
==================================

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 Parameter PC_WIDTH, 32, width of sampled PC.
REQ-002 Parameter MAX_CYCLES, 10, run-cycle budget; legal range 1..2^CNT_WIDTH-1.
REQ-003 Parameter CNT_WIDTH, 32, cycle counter width.
REQ-004 Parameter TRACE_DEPTH, 8, PC trace entries; power of two, >=2.
REQ-005 Parameter STALL_LIMIT, 4, consecutive repeated-PC samples that declare a stall; >=1.
REQ-006 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-007 Port rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port start  in  1  begin a run (honoured in IDLE and DONE only).
REQ-009 Port abort  in  1  terminate the run (honoured in RUN only).
REQ-010 Port pc_in  in  PC_WIDTH  PC presented by the CPU this cycle.
REQ-011 Port halt_addr  in  PC_WIDTH  halt address; halt_en  in  1  enables halt-address detection.
REQ-012 Port cpu_en  out  1  CPU clock enable; high exactly when state is RUN.
REQ-013 Port busy  out  1  state is RUN; done  out  1  state is DONE.
REQ-014 Port status  out  3  termination cause: 0 NONE, 1 BUDGET, 2 HALT, 3 STALL, 4 ABORT.
REQ-015 Port cycle_count  out  CNT_WIDTH  number of counted RUN cycles in current/last run.
REQ-016 Port trace_idx  in  log2(TRACE_DEPTH)  read index, 0 = newest sample; trace_pc  out  PC_WIDTH  combinational read data; trace_count  out  log2(TRACE_DEPTH)+1  valid entries.

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE/DONE + start -> RUN; RUN + termination -> DONE; otherwise hold.
REQ-018 On entry to RUN: cycle_count, trace_count, stall repeat counter cleared, status set NONE, no previous PC held.
REQ-019 Each RUN cycle without abort is a counted cycle: cycle_count increments, pc_in pushed to trace, pc_in kept as previous PC.
REQ-020 Halt: counted cycle with halt_en=1 and pc_in==halt_addr terminates with HALT.
REQ-021 Stall: repeat counter increments when counted pc_in equals previous PC, else clears; reaching STALL_LIMIT terminates with STALL; first sample of a run never counts as a repeat.
REQ-022 Budget: counted cycle bringing cycle_count to MAX_CYCLES terminates with BUDGET; cpu_en high for exactly MAX_CYCLES cycles if nothing else fires.
REQ-023 Abort in RUN: cycle not counted, no trace push, terminate with ABORT.
REQ-024 Simultaneous causes resolved by priority ABORT > HALT > STALL > BUDGET.
REQ-025 start while RUN ignored; abort outside RUN ignored; start and abort together in DONE -> start wins.
REQ-026 Trace is circular: write pointer wraps mod TRACE_DEPTH, oldest entry overwritten, trace_count saturates at TRACE_DEPTH.
REQ-027 trace_pc returns 0 when trace_idx >= trace_count.
REQ-028 cycle_count, status, trace contents hold their values in DONE until the next start.

Reset
REQ-029 rst_n low forces, asynchronously: state IDLE, cpu_en 0, busy 0, done 0, status NONE, cycle_count 0, trace_count 0, write pointer 0, repeat counter 0.
REQ-030 Reset asserted mid-run aborts without recording ABORT; trace storage array need not be cleared.

Structure
REQ-031 Status and FSM state encodings live in a shared include-guarded header cpu_run_defs.v, reused by testbenches.
REQ-032 Circular buffer with newest-relative read is sub-module pc_trace_buf (params WIDTH, DEPTH; ports clk, rst_n, clr, push, din, rd_idx, rd_data, count).

Verification (PC_WIDTH 32, MAX_CYCLES 10, TRACE_DEPTH 8, STALL_LIMIT 4)
REQ-033 Budget: start, pc_in 0x00,+4 per cycle, halt_en 0 -> done after 10 cpu_en cycles, status 1, cycle_count 10, trace_count 8, trace_pc[0]=0x24, trace_pc[7]=0x08.
REQ-034 Halt: same stimulus, halt_en 1, halt_addr 0x10 -> status 2, cycle_count 5, trace_pc[0]=0x10.
REQ-035 Stall: pc_in held 0x20 -> status 3, cycle_count 5; with halt_addr 0x20 enabled -> status 2, cycle_count 1.
REQ-036 Abort: abort asserted during 4th RUN cycle -> status 4, cycle_count 3, trace_count 3; halt_addr 0x24 hit on 10th cycle -> status 2 over BUDGET.
REQ-037 Reset: rst_n low mid-run (cycle 6), asynchronously between edges -> cpu_en 0 immediately, IDLE, status 0, cycle_count 0; subsequent start runs cleanly to status 1.
REQ-038 Restart: start in DONE -> RUN next edge with cycle_count 0, trace_count 0, trace_pc[0]=0.

Source files
------------

// File: rtl/cpu_run_monitor_pkg.sv
// Shared encodings for the CPU run monitor: FSM states, termination causes
// and the cause-priority helper. This file is guarded so that design files
// and testbenches can each pull it in without duplicate definitions.
`ifndef CPU_RUN_MONITOR_PKG_SV
`define CPU_RUN_MONITOR_PKG_SV

package cpu_run_monitor_pkg;

    // Width of the externally visible status code.
    localparam int STATUS_W = 3;

    // Run-control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } run_state_e;

    // Termination cause reported on the status port.
    typedef enum logic [STATUS_W-1:0] {
        STAT_NONE   = 3'd0,
        STAT_BUDGET = 3'd1,
        STAT_HALT   = 3'd2,
        STAT_STALL  = 3'd3,
        STAT_ABORT  = 3'd4
    } run_status_e;

    // Resolve simultaneous termination causes: ABORT > HALT > STALL > BUDGET.
    function automatic run_status_e pick_cause(
        input logic abort_hit,
        input logic halt_hit,
        input logic stall_hit,
        input logic budget_hit
    );
        if (abort_hit)       return STAT_ABORT;
        else if (halt_hit)   return STAT_HALT;
        else if (stall_hit)  return STAT_STALL;
        else if (budget_hit) return STAT_BUDGET;
        return STAT_NONE;
    endfunction

endpackage

`endif

// File: rtl/cpu_run_monitor_pc_trace_buf.sv
// Circular PC trace buffer. Entries are written at a wrapping write pointer;
// reads are addressed relative to the newest entry (rd_idx 0 = newest).
// Reads beyond the number of valid entries return zero.
module pc_trace_buf #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt_q;
    logic [AW-1:0]    rd_ptr;

    // Write pointer and valid-entry count; clear takes priority over push.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (cnt_q != FULL_CNT) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end
        end
    end

    // Trace storage; only written on push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; the
        // valid count masks stale contents, so no reset fan-out is needed.
        if (push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Newest-relative read: the newest entry sits one behind the write pointer.
    always_comb begin
        rd_ptr  = wr_ptr - AW'(1) - rd_idx;
        rd_data = ({1'b0, rd_idx} < cnt_q) ? mem[rd_ptr] : '0;
    end

    assign count = cnt_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// CPU run monitor: gates the CPU clock enable for one run and terminates the
// run on a cycle budget, a halt-address hit, a repeated-PC stall or an
// external abort. The PCs sampled during the run are kept in a circular trace.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter  int PC_WIDTH    = 32,
    parameter  int MAX_CYCLES  = 10,
    parameter  int CNT_WIDTH   = 32,
    parameter  int TRACE_DEPTH = 8,
    parameter  int STALL_LIMIT = 4,
    localparam int IDX_W       = $clog2(TRACE_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PC_WIDTH-1:0]  pc_in,
    input  logic [PC_WIDTH-1:0]  halt_addr,
    input  logic                 halt_en,
    output logic                 cpu_en,
    output logic                 busy,
    output logic                 done,
    output logic [STATUS_W-1:0]  status,
    output logic [CNT_WIDTH-1:0] cycle_count,
    input  logic [IDX_W-1:0]     trace_idx,
    output logic [PC_WIDTH-1:0]  trace_pc,
    output logic [IDX_W:0]       trace_count
);

    // Repeat counter only needs to reach STALL_LIMIT before the run ends.
    localparam int RPT_W = $clog2(STALL_LIMIT + 1);

    run_state_e           state_q, state_d;
    run_status_e          status_q, status_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]  prev_q, prev_d;
    logic                 have_prev_q, have_prev_d;
    logic [RPT_W-1:0]     rpt_q, rpt_d;

    logic                 trace_clr;
    logic                 trace_push;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [RPT_W-1:0]     rpt_inc;
    logic                 is_repeat;
    logic                 halt_hit;
    logic                 stall_hit;
    logic                 budget_hit;

    // Candidate values for a counted cycle; only used while in RUN.
    always_comb begin
        cnt_inc    = cnt_q + CNT_WIDTH'(1);
        is_repeat  = have_prev_q && (pc_in == prev_q);
        rpt_inc    = is_repeat ? (rpt_q + RPT_W'(1)) : '0;
        halt_hit   = halt_en && (pc_in == halt_addr);
        stall_hit  = (rpt_inc == RPT_W'(STALL_LIMIT));
        budget_hit = (cnt_inc == CNT_WIDTH'(MAX_CYCLES));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and run bookkeeping.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_d     = state_q;
        status_d    = status_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        rpt_d       = rpt_q;
        trace_clr   = 1'b0;
        trace_push  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // Start wins over any abort that arrives alongside it.
                if (start) begin
                    state_d     = ST_RUN;
                    status_d    = STAT_NONE;
                    cnt_d       = '0;
                    have_prev_d = 1'b0;
                    rpt_d       = '0;
                    trace_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!abort) begin
                    cnt_d       = cnt_inc;
                    prev_d      = pc_in;
                    have_prev_d = 1'b1;
                    rpt_d       = rpt_inc;
                    trace_push  = 1'b1;
                end
                if (abort || halt_hit || stall_hit || budget_hit) begin
                    state_d  = ST_DONE;
                    status_d = pick_cause(abort, halt_hit, stall_hit, budget_hit);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run counters, previous-PC tracking and termination status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q    <= STAT_NONE;
            cnt_q       <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            rpt_q       <= '0;
        end else begin
            status_q    <= status_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            rpt_q       <= rpt_d;
        end
    end

    pc_trace_buf #(
        .WIDTH (PC_WIDTH),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (trace_clr),
        .push    (trace_push),
        .din     (pc_in),
        .rd_idx  (trace_idx),
        .rd_data (trace_pc),
        .count   (trace_count)
    );

    assign cpu_en      = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign status      = status_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: a table of directed runs, a few
// hand-written multi-cycle sequences, and randomized runs compared against a
// queue-based model of a run's termination rules.
module tb_cpu_run_monitor;
    import cpu_run_monitor_pkg::*;

    localparam int PC_W    = 32;
    localparam int MAX_C   = 10;
    localparam int CNT_W   = 32;
    localparam int DEPTH   = 8;
    localparam int STALL_L = 4;
    localparam int IDX_W   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             halt_en = 1'b0;
    logic [PC_W-1:0]  pc_in = '0;
    logic [PC_W-1:0]  halt_addr = '0;
    logic [IDX_W-1:0] trace_idx = '0;
    logic             cpu_en;
    logic             busy;
    logic             done;
    logic [2:0]       status;
    logic [CNT_W-1:0] cycle_count;
    logic [PC_W-1:0]  trace_pc;
    logic [IDX_W:0]   trace_count;

    int total = 0;
    int bad   = 0;

    cpu_run_monitor #(
        .PC_WIDTH    (PC_W),
        .MAX_CYCLES  (MAX_C),
        .CNT_WIDTH   (CNT_W),
        .TRACE_DEPTH (DEPTH),
        .STALL_LIMIT (STALL_L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .pc_in       (pc_in),
        .halt_addr   (halt_addr),
        .halt_en     (halt_en),
        .cpu_en      (cpu_en),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .cycle_count (cycle_count),
        .trace_idx   (trace_idx),
        .trace_pc    (trace_pc),
        .trace_count (trace_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc0;
        logic [31:0] step;
        logic        hold;
        logic        hen;
        logic [31:0] haddr;
        logic [7:0]  abort_at;
        logic [2:0]  st;
        logic [7:0]  cnt;
        logic [3:0]  tcnt;
        logic [31:0] newest;
        logic [31:0] idx7;
        logic [7:0]  en_cyc;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_trace(input int idx, output logic [PC_W-1:0] val);
        trace_idx = IDX_W'(idx);
        #1;
        val = trace_pc;
    endtask

    function automatic vec_t mk(input logic [31:0] pc0, input logic [31:0] step,
                                input logic hold, input logic hen, input logic [31:0] haddr,
                                input int ab, input int st, input int cnt, input int tcnt,
                                input logic [31:0] newest, input logic [31:0] idx7, input int en);
        vec_t v;
        v.pc0      = pc0;
        v.step     = step;
        v.hold     = hold;
        v.hen      = hen;
        v.haddr    = haddr;
        v.abort_at = 8'(ab);
        v.st       = 3'(st);
        v.cnt      = 8'(cnt);
        v.tcnt     = 4'(tcnt);
        v.newest   = newest;
        v.idx7     = idx7;
        v.en_cyc   = 8'(en);
        return v;
    endfunction

    // Start a run from IDLE/DONE, drive the vector's PC stream until the
    // monitor leaves RUN (bounded), then compare the final state.
    task automatic run_vec(input int id, input vec_t v);
        int k;
        int en;
        logic [PC_W-1:0] tp;
        halt_en   = v.hen;
        halt_addr = v.haddr;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("v%0d_enter_busy", id), 64'(busy), 64'd1);
        check($sformatf("v%0d_enter_cnt", id), 64'(cycle_count), 64'd0);
        en = 0;
        k  = 1;
        while (busy && en < 40) begin
            pc_in = v.hold ? v.pc0 : v.pc0 + v.step * 32'(k - 1);
            abort = (k == int'(v.abort_at));
            en++;
            k++;
            tick();
        end
        abort = 1'b0;
        check($sformatf("v%0d_done", id), 64'(done), 64'd1);
        check($sformatf("v%0d_cpu_en_cycles", id), 64'(en), 64'(v.en_cyc));
        check($sformatf("v%0d_status", id), 64'(status), 64'(v.st));
        check($sformatf("v%0d_cycle_count", id), 64'(cycle_count), 64'(v.cnt));
        check($sformatf("v%0d_trace_count", id), 64'(trace_count), 64'(v.tcnt));
        read_trace(0, tp);
        check($sformatf("v%0d_trace0", id), 64'(tp), 64'(v.newest));
        read_trace(7, tp);
        check($sformatf("v%0d_trace7", id), 64'(tp), 64'(v.idx7));
    endtask

    // Randomized run checked against a model that keeps the run's counted PCs
    // in a queue and applies the termination rules to that history.
    task automatic rand_run(input int r);
        logic [PC_W-1:0] q[$];
        logic [PC_W-1:0] cur;
        logic [PC_W-1:0] tp;
        logic [PC_W-1:0] exp_pc;
        logic [2:0]      exp_st;
        bit              exp_done;
        bit              h, s, b, eq;
        int              guard;
        int              n;
        exp_st    = 3'd0;
        exp_done  = 1'b0;
        guard     = 0;
        halt_en   = 1'($urandom_range(0, 1));
        halt_addr = 32'($urandom_range(0, 7)) * 32'd4;
        start     = 1'b1;
        tick();
        start = 1'b0;
        cur = 32'($urandom_range(0, 3)) * 32'd4;
        while (!exp_done && guard < 40) begin
            if ($urandom_range(0, 1) == 1) cur = 32'($urandom_range(0, 3)) * 32'd4;
            pc_in = cur;
            abort = ($urandom_range(0, 19) == 0);
            if (abort) begin
                exp_done = 1'b1;
                exp_st   = 3'd4;
            end else begin
                q.push_back(cur);
                h  = halt_en && (cur == halt_addr);
                eq = (q.size() > STALL_L);
                for (int i = 1; i <= STALL_L && eq; i++) begin
                    if (q[q.size() - 1 - i] != cur) eq = 1'b0;
                end
                s = eq;
                b = (q.size() == MAX_C);
                if (h)      exp_st = 3'd2;
                else if (s) exp_st = 3'd3;
                else if (b) exp_st = 3'd1;
                exp_done = h || s || b;
            end
            tick();
            guard++;
            check($sformatf("r%0d_done_c%0d", r, guard), 64'(done), 64'(exp_done));
        end
        abort = 1'b0;
        n = q.size();
        check($sformatf("r%0d_status", r), 64'(status), 64'(exp_st));
        check($sformatf("r%0d_cycle_count", r), 64'(cycle_count), 64'(n));
        check($sformatf("r%0d_trace_count", r), 64'(trace_count), 64'((n > DEPTH) ? DEPTH : n));
        for (int i = 0; i < DEPTH; i++) begin
            exp_pc = (i < n) ? q[n - 1 - i] : '0;
            read_trace(i, tp);
            check($sformatf("r%0d_trace%0d", r, i), 64'(tp), 64'(exp_pc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PC_W-1:0] tp;

        //             pc0    step  hold hen haddr ab st cnt tc newest idx7  en
        vecs[0] = mk(32'h00, 32'h4, 0, 0, 32'h00, 0, 1, 10, 8, 32'h24, 32'h08, 10);
        vecs[1] = mk(32'h00, 32'h4, 0, 1, 32'h10, 0, 2,  5, 5, 32'h10, 32'h00,  5);
        vecs[2] = mk(32'h20, 32'h0, 1, 0, 32'h00, 0, 3,  5, 5, 32'h20, 32'h00,  5);
        vecs[3] = mk(32'h20, 32'h0, 1, 1, 32'h20, 0, 2,  1, 1, 32'h20, 32'h00,  1);
        vecs[4] = mk(32'h00, 32'h4, 0, 0, 32'h00, 4, 4,  3, 3, 32'h08, 32'h00,  4);
        vecs[5] = mk(32'h00, 32'h4, 0, 1, 32'h24, 0, 2, 10, 8, 32'h24, 32'h08, 10);
        vecs[6] = mk(32'h00, 32'h4, 0, 1, 32'h10, 5, 4,  4, 4, 32'h0c, 32'h00,  5);

        // Reset state.
        #12;
        check("rst_cpu_en", 64'(cpu_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_cycle_count", 64'(cycle_count), 64'd0);
        check("rst_trace_count", 64'(trace_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort outside RUN is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'd0);
        check("idle_abort_done", 64'(done), 64'd0);
        check("idle_abort_status", 64'(status), 64'd0);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // DONE holds its results until the next start.
        run_vec(100, vecs[0]);
        repeat (3) tick();
        check("hold_status", 64'(status), 64'd1);
        check("hold_cycle_count", 64'(cycle_count), 64'd10);
        read_trace(0, tp);
        check("hold_trace0", 64'(tp), 64'h24);

        // Restart from DONE with abort alongside: start wins, state clears.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_status", 64'(status), 64'd0);
        check("restart_cycle_count", 64'(cycle_count), 64'd0);
        check("restart_trace_count", 64'(trace_count), 64'd0);
        read_trace(0, tp);
        check("restart_trace0", 64'(tp), 64'd0);
        tick();
        abort = 1'b0;
        check("restart_abort_status", 64'(status), 64'd4);
        check("restart_abort_count", 64'(cycle_count), 64'd0);

        // Start while RUN is ignored: counting continues.
        halt_en = 1'b0;
        start   = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            pc_in = 32'(k) * 32'd4;
            tick();
        end
        start = 1'b0;
        check("run_start_ignored_count", 64'(cycle_count), 64'd3);
        check("run_start_ignored_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("run_start_ignored_status", 64'(status), 64'd4);

        // Asynchronous reset in the middle of the sixth RUN cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pc_in = 32'(k) * 32'd4;
            tick();
        end
        pc_in = 32'h14;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_cpu_en", 64'(cpu_en), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        check("async_rst_status", 64'(status), 64'd0);
        check("async_rst_cycle_count", 64'(cycle_count), 64'd0);
        check("async_rst_trace_count", 64'(trace_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(200, vecs[0]);

        // Randomized runs against the model.
        for (int r = 0; r < 30; r++) begin
            rand_run(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
